mac_conv3x3_cfg: RTL and testbench
==================================

// Module: mac_conv3x3_cfg
// PURPOSE
//  Parametrised 3x3 convolution MAC. Successor to the fixed sharpen MAC.
//  Takes one 3x3 window per accepted beat from the line-buffer stage and emits
//  one output pixel. The kernel is runtime-loadable through double-buffered
//  coefficient registers. Normalisation is a rounding right shift, followed by
//  a saturating clamp. Downstream can apply backpressure with a ready signal.
// PARAMETERS
//  PIXEL_W  8  unsigned pixel width, for both input taps and output
//  COEF_W   8  signed two's-complement coefficient width
//  SHIFT_W  4  width of the normalisation shift field (shift 0..2^SHIFT_W-1)
//  ACC_W    PIXEL_W+COEF_W+5  accumulator width (derived, not overridable)
// PORTS
//  clk               in   1           rising-edge clock
//  rst               in   1           synchronous active-high reset
//  pixel_data        in   9*PIXEL_W   window, tap i at [i*PIXEL_W +: PIXEL_W], i=0 top-left, raster order
//  pixel_data_valid  in   1           window valid
//  pixel_data_ready  out  1           block accepts window this cycle
//  cfg_we            in   1           write one shadow coefficient
//  cfg_addr          in   4           coefficient index 0..8; 9 = shift register; 10..15 ignored
//  cfg_wdata         in   COEF_W      coef value; for addr 9, [SHIFT_W-1:0] is the shift
//  cfg_commit        in   1           copy shadow bank to active bank
//  o_pixel           out  PIXEL_W     result pixel
//  o_pixel_valid     out  1           result valid
//  o_pixel_ready     in   1           downstream accepts result
// BEHAVIOUR
//  - Reset: o_pixel=0; o_pixel_valid=0; all stage valids=0.
//    Active and shadow kernels = {0,-1,0,-1,5,-1,0,-1,0}; shift=0 (sharpen).
//  - Handshake: stall = o_pixel_valid & ~o_pixel_ready.
//    pixel_data_ready = ~stall. A window is accepted when valid&ready.
//    During stall every stage holds, and o_pixel/o_pixel_valid stay stable.
//  - Pipeline, latency 3 accepted cycles (accept at N -> o_pixel_valid at N+3
//    with no stall):
//    S1 registers the 9 products coef[i]*$signed({1'b0,tap[i]}), each PIXEL_W+COEF_W+1 wide.
//    S2 registers the sign-extended sum in ACC_W.
//    S3 normalises and clamps into o_pixel.
//  - Normalise: if shift>0, add 1<<(shift-1) and then arithmetic-shift right by shift.
//    If shift=0, pass the sum through.
//  - Clamp: result<0 -> 0; result>2^PIXEL_W-1 -> 2^PIXEL_W-1.
//  - Coefficient bank: cfg_we writes the shadow bank only. cfg_commit copies
//    shadow to active at the clock edge.
//    - A window accepted in the commit cycle uses the old active bank.
//    - The next window uses the new bank.
//    - Windows already in flight are unaffected.
//  - cfg_we and cfg_commit in the same cycle: the commit copies the pre-write
//    shadow, and the write lands in shadow only.
//  - Commit is legal during a stall and takes effect for the next accepted window.
//  - Reset mid-operation: in-flight data is dropped, valids clear, banks return
//    to the default.
//  - Overflow cannot occur in ACC_W. Worst case is 9*(2^PIXEL_W-1)*2^(COEF_W-1).
// CONFIGURATION
//  MAC_CONV_ABS_OUT_EN defined: negative normalised results are replaced by
//  their magnitude before the upper clamp (edge-magnitude mode).
//  Undefined: negative results clamp to 0.
//  The reset kernel, latency and ports are identical in both builds.
// STRUCTURE
//  Shared package conv_pkg holds:
//  - localparam KERNEL_SHARPEN[0:8]
//  - CFG_ADDR_SHIFT = 9
//  - function acc_width(pw,cw)
//  Sub-module conv_norm_sat (ACC_W in, PIXEL_W out, combinational round/shift/clamp,
//  abs option) is the S3 datapath. The top registers its output.
// TESTING
//  1 Reset, default kernel, all taps 100, shift 0 -> o_pixel=100 three cycles after accept.
//  2 Default kernel, centre 255, others 0 -> 1275 clamps to 255. Centre 0, others 255 -> -1020 gives 0
//    (255 with MAC_CONV_ABS_OUT_EN).
//  3 Write box kernel (all 1) with shift 3, commit, all taps 7 -> 63+4=67>>3 = 8.
//    Windows accepted before the commit still use the sharpen kernel.
//  4 cfg_we addr4=9 and cfg_commit in the same cycle -> active centre unchanged.
//    A second commit applies centre 9: centre tap 10, others 0 -> 90.
//  5 Stream 10 windows with o_pixel_ready low for 4 cycles mid-stream.
//    Outputs are in order, none dropped or duplicated, and o_pixel is held stable while stalled.
//  6 Assert rst with 2 windows in flight -> o_pixel_valid=0 the next cycle and the kernel
//    reverts to sharpen. A later all-50 window gives 50.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution MAC: reset kernel, config address map
// and the accumulator width helper.
package conv_pkg;

  localparam int NUM_TAPS = 9;
  localparam int KERNEL_SHARPEN [0:8] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
  localparam logic [3:0] CFG_ADDR_SHIFT = 4'd9;

  function automatic int acc_width(input int pw, input int cw);
    return pw + cw + 5;
  endfunction

endpackage

// File: rtl/conv_norm_sat.sv
// Combinational rounding right shift and saturating clamp into a pixel.
// MAC_CONV_ABS_OUT_EN: negative results are replaced by their magnitude before clamping.
module conv_norm_sat
  import conv_pkg::*;
#(
  parameter int ACC_W   = 21,
  parameter int PIXEL_W = 8,
  parameter int SHIFT_W = 4
) (
  input  logic signed [ACC_W-1:0]   i_sum,
  input  logic        [SHIFT_W-1:0] i_shift,
  output logic        [PIXEL_W-1:0] o_pix
);

  logic        [ACC_W:0] w_one;
  logic        [ACC_W:0] w_round;
  logic signed [ACC_W:0] w_biased;
  logic signed [ACC_W:0] w_shifted;
  logic signed [ACC_W:0] w_mag;

  assign w_one = {{ACC_W{1'b0}}, 1'b1};

  // One extra bit of headroom so the rounding bias can never wrap the sum.
  always_comb begin
    w_round   = (w_one << i_shift) >> 1;
    w_biased  = $signed({i_sum[ACC_W-1], i_sum}) + $signed(w_round);
    w_shifted = w_biased >>> i_shift;
`ifdef MAC_CONV_ABS_OUT_EN
    if (w_shifted[ACC_W]) begin
      w_mag = -w_shifted;
    end else begin
      w_mag = w_shifted;
    end
`else
    w_mag = w_shifted;
`endif
    if (w_mag[ACC_W]) begin
      o_pix = '0;
    end else if (|w_mag[ACC_W-1:PIXEL_W]) begin
      o_pix = '1;
    end else begin
      o_pix = w_mag[PIXEL_W-1:0];
    end
  end

endmodule

// File: rtl/mac_conv3x3_cfg.sv
// 3x3 convolution MAC with double-buffered runtime kernel, 3-stage pipeline and backpressure.
// MAC_CONV_ABS_OUT_EN selects edge-magnitude output (handled in conv_norm_sat).
module mac_conv3x3_cfg
  import conv_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int COEF_W  = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9*PIXEL_W-1:0]   pixel_data,
  input  logic                   pixel_data_valid,
  output logic                   pixel_data_ready,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_addr,
  input  logic [COEF_W-1:0]      cfg_wdata,
  input  logic                   cfg_commit,
  output logic [PIXEL_W-1:0]     o_pixel,
  output logic                   o_pixel_valid,
  input  logic                   o_pixel_ready
);

  localparam int ACC_W  = acc_width(PIXEL_W, COEF_W);
  localparam int PROD_W = PIXEL_W + COEF_W + 1;

  logic signed [COEF_W-1:0]  r_shadow_coef [NUM_TAPS];
  logic        [SHIFT_W-1:0] r_shadow_shift;
  logic signed [COEF_W-1:0]  r_active_coef [NUM_TAPS];
  logic        [SHIFT_W-1:0] r_active_shift;

  logic signed [PROD_W-1:0]  r_s1_prod [NUM_TAPS];
  logic        [SHIFT_W-1:0] r_s1_shift;
  logic                      r_s1_valid;
  logic signed [ACC_W-1:0]   r_s2_sum;
  logic        [SHIFT_W-1:0] r_s2_shift;
  logic                      r_s2_valid;
  logic        [PIXEL_W-1:0] r_pixel;
  logic                      r_pixel_valid;

  logic                      w_stall;
  logic                      w_accept;
  logic signed [PROD_W-1:0]  w_prod [NUM_TAPS];
  logic signed [ACC_W-1:0]   w_sum;
  logic        [PIXEL_W-1:0] w_norm;

  assign w_stall          = r_pixel_valid & ~o_pixel_ready;
  assign w_accept         = pixel_data_valid & ~w_stall;
  assign pixel_data_ready = ~w_stall;
  assign o_pixel          = r_pixel;
  assign o_pixel_valid    = r_pixel_valid;

  // Kernel banks; the commit copies the shadow as it was before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_shadow_coef[i] <= COEF_W'(KERNEL_SHARPEN[i]);
        r_active_coef[i] <= COEF_W'(KERNEL_SHARPEN[i]);
      end
      r_shadow_shift <= '0;
      r_active_shift <= '0;
    end else begin
      if (cfg_commit) begin
        r_active_coef  <= r_shadow_coef;
        r_active_shift <= r_shadow_shift;
      end
      if (cfg_we) begin
        for (int i = 0; i < NUM_TAPS; i++) begin
          if (cfg_addr == 4'(i)) begin
            r_shadow_coef[i] <= cfg_wdata;
          end
        end
        if (cfg_addr == CFG_ADDR_SHIFT) begin
          r_shadow_shift <= cfg_wdata[SHIFT_W-1:0];
        end
      end
    end
  end

  // Taps are zero-extended so they stay non-negative in the signed multiply.
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      w_prod[i] = $signed({{(PROD_W-COEF_W){r_active_coef[i][COEF_W-1]}}, r_active_coef[i]})
                * $signed({{(PROD_W-PIXEL_W){1'b0}}, pixel_data[i*PIXEL_W +: PIXEL_W]});
    end
  end

  // Adder tree over the sign-extended S1 products.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      w_sum = w_sum + {{(ACC_W-PROD_W){r_s1_prod[i][PROD_W-1]}}, r_s1_prod[i]};
    end
  end

  conv_norm_sat #(
    .ACC_W   (ACC_W),
    .PIXEL_W (PIXEL_W),
    .SHIFT_W (SHIFT_W)
  ) u_norm (
    .i_sum   (r_s2_sum),
    .i_shift (r_s2_shift),
    .o_pix   (w_norm)
  );

  // The shift travels with each window so a commit never affects data in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_s1_prod[i] <= '0;
      end
      r_s1_shift    <= '0;
      r_s1_valid    <= 1'b0;
      r_s2_sum      <= '0;
      r_s2_shift    <= '0;
      r_s2_valid    <= 1'b0;
      r_pixel       <= '0;
      r_pixel_valid <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_prod  <= w_prod;
        r_s1_shift <= r_active_shift;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum   <= w_sum;
        r_s2_shift <= r_s1_shift;
      end
      r_pixel_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_pixel <= w_norm;
      end
    end
  end

endmodule

// File: tb/tb_mac_conv3x3_cfg.sv
// Self-checking bench for mac_conv3x3_cfg: directed scenarios plus randomized traffic
// scored against an arithmetic reference model.
module tb_mac_conv3x3_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] pixel_data;
  logic        pixel_data_valid;
  logic        pixel_data_ready;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        cfg_commit;
  logic [7:0]  o_pixel;
  logic        o_pixel_valid;
  logic        o_pixel_ready;

  mac_conv3x3_cfg dut (
    .clk              (clk),
    .rst              (rst),
    .pixel_data       (pixel_data),
    .pixel_data_valid (pixel_data_valid),
    .pixel_data_ready (pixel_data_ready),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .cfg_commit       (cfg_commit),
    .o_pixel          (o_pixel),
    .o_pixel_valid    (o_pixel_valid),
    .o_pixel_ready    (o_pixel_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int act_k [9];
  int sh_k  [9];
  int act_sh;
  int sh_sh;
  int exp_q [$];
  int popped [$];
  bit prev_stall;
  int prev_pix;
  bit last_acc;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_pix(input int k[9], input int sh, input int t[9]);
    longint s = 0;
    for (int i = 0; i < 9; i++) s += longint'(k[i]) * longint'(t[i]);
    if (sh > 0) s = (s + (longint'(1) << (sh - 1))) >>> sh;
`ifdef MAC_CONV_ABS_OUT_EN
    if (s < 0) s = -s;
`endif
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return int'(s);
  endfunction

  function automatic logic [71:0] pack(input int t[9]);
    logic [71:0] p;
    for (int i = 0; i < 9; i++) p[i*8 +: 8] = t[i][7:0];
    return p;
  endfunction

  task automatic model_reset();
    int def_k [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    act_k = def_k;
    sh_k  = def_k;
    act_sh = 0;
    sh_sh  = 0;
    exp_q.delete();
    prev_stall = 1'b0;
  endtask

  // One clock cycle: drive inputs, score the output, advance the model.
  task automatic step(input bit v, input int t[9], input bit we, input int addr,
                      input int wd, input bit cm, input bit rdy);
    bit stall;
    int e;
    @(negedge clk);
    pixel_data       = pack(t);
    pixel_data_valid = v;
    cfg_we           = we;
    cfg_addr         = addr[3:0];
    cfg_wdata        = wd[7:0];
    cfg_commit       = cm;
    o_pixel_ready    = rdy;
    #1;
    stall = o_pixel_valid && !rdy;
    check_eq("in_ready", int'(pixel_data_ready), int'(!stall));
    if (prev_stall) begin
      check_eq("hold_pix", int'(o_pixel), prev_pix);
      check_eq("hold_vld", int'(o_pixel_valid), 1);
    end
    if (o_pixel_valid && rdy) begin
      check_eq("sb_avail", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("pix", int'(o_pixel), e);
        popped.push_back(int'(o_pixel));
      end
    end
    last_acc = v && !stall;
    if (last_acc) exp_q.push_back(model_pix(act_k, act_sh, t));
    if (cm) begin
      act_k  = sh_k;
      act_sh = sh_sh;
    end
    if (we) begin
      if (addr < 9) sh_k[addr] = int'($signed(wd[7:0]));
      else if (addr == 9) sh_sh = wd & 15;
    end
    prev_stall = stall;
    prev_pix   = int'(o_pixel);
    @(posedge clk);
  endtask

  task automatic idle(input bit rdy);
    int z [9] = '{default: 0};
    step(1'b0, z, 1'b0, 0, 0, 1'b0, rdy);
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (exp_q.size() != 0 || o_pixel_valid); k++) idle(1'b1);
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pixel_data_valid = 1'b0;
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
    o_pixel_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_vld", int'(o_pixel_valid), 0);
    check_eq("rst_pix", int'(o_pixel), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int t [9];
    int n;
    int acc;
    rst = 1'b1;
    pixel_data = '0;
    pixel_data_valid = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = 4'd0;
    cfg_wdata = 8'd0;
    cfg_commit = 1'b0;
    o_pixel_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_vld", int'(o_pixel_valid), 0);
    check_eq("reset_pix", int'(o_pixel), 0);
    check_eq("reset_rdy", int'(pixel_data_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // Default kernel, flat 100 field, latency of three cycles.
    t = '{default: 100};
    step(1'b1, t, 1'b0, 0, 0, 1'b0, 1'b1);
    idle(1'b1);
    #1;
    check_eq("t1_early_vld", int'(o_pixel_valid), 0);
    idle(1'b1);
    #1;
    check_eq("t1_lat_vld", int'(o_pixel_valid), 1);
    check_eq("t1_lat_pix", int'(o_pixel), 100);
    drain();

    // Saturation at both ends.
    t = '{default: 0};
    t[4] = 255;
    step(1'b1, t, 1'b0, 0, 0, 1'b0, 1'b1);
    t = '{default: 255};
    t[4] = 0;
    step(1'b1, t, 1'b0, 0, 0, 1'b0, 1'b1);
    drain();
    n = popped.size();
    check_eq("t2_hi_clamp", popped[n-2], 255);
`ifdef MAC_CONV_ABS_OUT_EN
    check_eq("t2_neg", popped[n-1], 255);
`else
    check_eq("t2_neg", popped[n-1], 0);
`endif

    // Box kernel with shift 3, commit boundary.
    t = '{default: 7};
    for (int i = 0; i < 9; i++) step(1'b0, t, 1'b1, i, 1, 1'b0, 1'b1);
    step(1'b0, t, 1'b1, 9, 3, 1'b0, 1'b1);
    step(1'b1, t, 1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b1, t, 1'b0, 0, 0, 1'b1, 1'b1);
    step(1'b1, t, 1'b0, 0, 0, 1'b0, 1'b1);
    drain();
    n = popped.size();
    check_eq("t3_pre", popped[n-3], 7);
    check_eq("t3_commit_cyc", popped[n-2], 7);
    check_eq("t3_box", popped[n-1], 8);

    // Write and commit in the same cycle, then a second commit.
    t = '{default: 0};
    t[4] = 10;
    step(1'b0, t, 1'b1, 4, 9, 1'b1, 1'b1);
    step(1'b1, t, 1'b0, 0, 0, 1'b0, 1'b1);
    drain();
    check_eq("t4_same_cyc", popped[popped.size()-1], 1);
    step(1'b0, t, 1'b1, 9, 0, 1'b0, 1'b1);
    step(1'b0, t, 1'b0, 0, 0, 1'b1, 1'b1);
    step(1'b1, t, 1'b0, 0, 0, 1'b0, 1'b1);
    drain();
    check_eq("t4_second", popped[popped.size()-1], 90);

    // Stream of 10 with a 4-cycle downstream stall.
    n = popped.size();
    acc = 0;
    for (int k = 0; k < 40 && acc < 10; k++) begin
      for (int i = 0; i < 9; i++) t[i] = $urandom_range(0, 255);
      step(1'b1, t, 1'b0, 0, 0, 1'b0, !(k >= 4 && k < 8));
      if (last_acc) acc++;
    end
    check_eq("t5_accepted", acc, 10);
    drain();
    check_eq("t5_count", popped.size() - n, 10);

    // Reset with windows in flight.
    t = '{default: 30};
    step(1'b1, t, 1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b1, t, 1'b0, 0, 0, 1'b0, 1'b1);
    do_reset();
    t = '{default: 50};
    step(1'b1, t, 1'b0, 0, 0, 1'b0, 1'b1);
    drain();
    check_eq("t6_after_rst", popped[popped.size()-1], 50);

    // Randomized traffic and reconfiguration.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 9; i++) t[i] = $urandom_range(0, 255);
      step($urandom_range(0, 9) < 7, t, $urandom_range(0, 9) == 0, $urandom_range(0, 15),
           $urandom_range(0, 255), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
